keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Matrix keypad front end for the door lock: the input-side counterpart of the multiplexed 7-seg driver.
//  - Strobes one column at a time and reads the four row lines back.
//  - Debounces across whole scans; emits one key code per press.
//  - Feeds the PIN-entry/compare logic upstream of the open display.
//  - Fixed 4-row x 3-column phone-style keypad.
// PARAMETERS
//  SCAN_DIV      1000  clocks per column slot; legal minimum is 4
//  DEBOUNCE      4     consecutive identical full scans needed to accept a press or a release; legal range 1..15
//  REPEAT_SCANS  50    scans between repeats while a key is held; used only when KEYPAD_REPEAT_EN is defined
// PORTS
//  clk        in   1  system clock; the only clock
//  rst        in   1  synchronous, active-high reset
//  row        in   4  row sense lines, active-high; asynchronous to clk
//  col        out  3  column strobes, active-high, one-hot
//  key_code   out  4  last accepted key: 0-9; '*'=4'hA; '#'=4'hB
//  key_valid  out  1  one-cycle pulse when key_code updates
//  key_held   out  1  level, high from acceptance until the release is debounced
// BEHAVIOUR
//  Reset values
//   - col=3'b001, key_code=4'h0, key_valid=0, key_held=0.
//   - All counters, the snapshot, the candidate and the sync flops clear to 0.
//   - A reset mid-press discards all state; a key still down is re-debounced and re-reported.
//  Row synchroniser
//   - row passes through 2 flops before use.
//  Column scan
//   - Slot counter counts 0..SCAN_DIV-1.
//   - At terminal count, col rotates 001->010->100->001.
//   - Synced rows are sampled into the 12-bit snapshot on slot count SCAN_DIV-1.
//     This allows settle time plus sync delay.
//   - Snapshot bit index = row*3 + col.
//  Scan-end evaluation (cycle after the col-2 sample)
//   - Zero bits set  -> candidate = NONE.
//   - Exactly one bit set -> candidate = that key.
//   - Two or more bits set -> candidate = GHOST.
//   - Key map: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
//  Debounce
//   - If candidate equals the previous scan's candidate, stab_cnt increments, saturating at DEBOUNCE.
//   - Otherwise stab_cnt = 1 and the previous candidate is replaced.
//   - GHOST never reaches acceptance and leaves key_held unchanged.
//  State machine
//   - IDLE: stab_cnt reaches DEBOUNCE on a key candidate ->
//     key_code <= key; key_valid pulses 1 cycle; key_held <= 1; go to HELD.
//   - HELD: stab_cnt reaches DEBOUNCE on NONE -> key_held <= 0; go to IDLE.
//   - HELD: a different key goes stable -> no event.
//     The key must be released (NONE stable) before the next press is reported.
//  Timing
//   - Latency from the first scan that sees a stable press to key_valid is DEBOUNCE full scans.
//     One full scan = 3*SCAN_DIV clocks.
//   - key_valid is registered.
//  Width rules
//   - Slot counter: $clog2(SCAN_DIV) bits.
//   - stab_cnt: 4 bits.
//   - Repeat counter: 8 bits, saturating.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined
//   - In HELD, every REPEAT_SCANS further scans with the same stable key, key_valid pulses again with the same key_code.
//   - The repeat counter clears on entry to HELD and on each repeat.
//  KEYPAD_REPEAT_EN undefined
//   - Exactly one key_valid per press.
//   - The repeat counter is not present in the design.
// TESTING (SCAN_DIV=4, DEBOUNCE=3, REPEAT_SCANS=2; full scan = 12 clk)
//  - Reset: hold rst for 3 clk -> col=001, key_code=0, key_valid=0, key_held=0.
//    Release -> col=010 after 4 clk, col=100 after 8 clk.
//  - Clean press '5': drive row=0010 whenever col=010 for 5 scans.
//    -> Exactly one key_valid pulse, key_code=4'h5, key_held=1.
//    -> key_held=0 three scans after release.
//  - Bounce: toggle row1 every 7 clk for 4 scans, then hold it stable.
//    -> No key_valid during bouncing.
//    -> key_valid fires only after 3 stable scans.
//  - Ghost: press '1' and '#' together for 6 scans -> no key_valid, key_held stays 0.
//    Then release '#' -> key_valid with key_code=4'h1.
//  - Rollover/reset: hold '*' until key_held=1, press '0', assert rst for 1 clk mid-scan.
//    -> All outputs return to reset values.
//    -> With '0' still held, key_valid/key_code=4'h0 follows 3 scans later.
//  - KEYPAD_REPEAT_EN: hold '9' for 10 scans -> key_valid pulses at scan 3, then at scans 5, 7 and 9.
//    key_code=4'h9 on every pulse.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with whole-scan debounce.
// Strobes one column per slot, snapshots the synchronised row lines into a
// 12-bit image, classifies each completed image (none / one key / ghost) and
// reports one key_code per press once the classification has been stable
// for DEBOUNCE scans.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_SCANS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]   SLOT_ONE  = SW'(1);
    localparam logic [3:0]      DEB       = 4'(DEBOUNCE);

    // Out-of-range parameters keep the scanner running but never evaluate a
    // scan, so the keypad stays silent instead of misreporting.
    localparam logic PARAMS_OK = (SCAN_DIV >= 4) && (DEBOUNCE >= 1) &&
                                 (DEBOUNCE <= 15) && (REPEAT_SCANS >= 1);

    // Candidate encoding: 0 = no key, 1..12 = snapshot index + 1, 13 = ghost.
    localparam logic [3:0] CAND_NONE  = 4'd0;
    localparam logic [3:0] CAND_GHOST = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [SW-1:0] slot_q;
    logic [2:0]    col_q;
    logic [11:0]   snap_q, snap_d;
    logic          scan_end_q;
    logic [3:0]    prev_cand_q;
    logic [3:0]    stab_cnt_q, stab_cnt_d;
    state_t        state_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
`ifdef KEYPAD_REPEAT_EN
    logic [7:0]    rep_cnt_q, rep_cnt_inc;
    localparam logic [7:0] REP = 8'(REPEAT_SCANS);
`endif

    logic [3:0] ones;
    logic [3:0] first_idx;
    logic [3:0] cand;
    logic [3:0] cand_code;
    logic       cand_is_key;
    logic       cand_stable;
    logic       scan_eval;

    // Snapshot update: the active column's bits take the synced rows at the
    // last clock of the slot, giving the strobe time to settle through the
    // two-flop synchroniser.
    always_comb begin
        snap_d = snap_q;
        if (slot_q == SLOT_LAST) begin
            for (int i = 0; i < 12; i++) begin
                if (col_q[i % 3]) begin
                    snap_d[i] = row_s2_q[i / 3];
                end
            end
        end
    end

    // Row synchroniser, slot counter, column rotation and snapshot capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q   <= '0;
            row_s2_q   <= '0;
            slot_q     <= '0;
            col_q      <= 3'b001;
            snap_q     <= '0;
            scan_end_q <= 1'b0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            snap_q     <= snap_d;
            scan_end_q <= (slot_q == SLOT_LAST) && col_q[2];
            if (slot_q == SLOT_LAST) begin
                slot_q <= '0;
                col_q  <= {col_q[1:0], col_q[2]};
            end else begin
                slot_q <= slot_q + SLOT_ONE;
            end
        end
    end

    // Classify the completed snapshot: count set bits and remember the one set.
    always_comb begin
        ones      = 4'd0;
        first_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (snap_q[i]) begin
                ones      = ones + 4'd1;
                first_idx = 4'(i);
            end
        end
        if (ones == 4'd0) begin
            cand = CAND_NONE;
        end else if (ones == 4'd1) begin
            cand = first_idx + 4'd1;
        end else begin
            cand = CAND_GHOST;
        end
    end

    // Map candidate to the phone-style key code; digits 1..9 coincide with
    // the candidate value itself.
    always_comb begin
        case (cand)
            4'd10:   cand_code = 4'hA;
            4'd11:   cand_code = 4'h0;
            4'd12:   cand_code = 4'hB;
            default: cand_code = cand;
        endcase
    end

    // Stability count for the candidate of this scan, saturating at DEBOUNCE.
    always_comb begin
        if (cand == prev_cand_q) begin
            stab_cnt_d = (stab_cnt_q >= DEB) ? DEB : stab_cnt_q + 4'd1;
        end else begin
            stab_cnt_d = 4'd1;
        end
    end

    assign cand_is_key = (cand != CAND_NONE) && (cand != CAND_GHOST);
    assign cand_stable = (stab_cnt_d == DEB);
    assign scan_eval   = scan_end_q && PARAMS_OK;

`ifdef KEYPAD_REPEAT_EN
    assign rep_cnt_inc = (rep_cnt_q == 8'hFF) ? 8'hFF : rep_cnt_q + 8'd1;
`endif

    // Debounce bookkeeping and press/release state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_cand_q <= CAND_NONE;
            stab_cnt_q  <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (scan_eval) begin
                prev_cand_q <= cand;
                stab_cnt_q  <= stab_cnt_d;
                case (state_q)
                    ST_IDLE: begin
                        if (cand_stable && cand_is_key) begin
                            key_code_q  <= cand_code;
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            state_q     <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_q   <= '0;
`endif
                        end
                    end
                    ST_HELD: begin
                        // A different stable key or a ghost is ignored here:
                        // only a debounced release re-arms the scanner.
                        if (cand_stable && (cand == CAND_NONE)) begin
                            key_held_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
`ifdef KEYPAD_REPEAT_EN
                        // Repeat counts only consecutive scans of the same
                        // held key; anything else restarts the interval.
                        else if (cand_stable && cand_is_key &&
                                 (cand_code == key_code_q)) begin
                            if (rep_cnt_inc >= REP) begin
                                key_valid_q <= 1'b1;
                                rep_cnt_q   <= '0;
                            end else begin
                                rep_cnt_q   <= rep_cnt_inc;
                            end
                        end else begin
                            rep_cnt_q <= '0;
                        end
`endif
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3,
// REPEAT_SCANS=2). The driver holds one key set per full scan, steps a
// scan-level reference model and queues the expected outcome; the monitor
// tracks time since reset, checks the column strobe every clock and pops one
// expectation each time a scan result becomes visible.
module tb_keypad_scan;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int RS   = 2;
    localparam int SCAN = 3 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [11:0] pressed = '0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV    (SD),
        .DEBOUNCE    (DB),
        .REPEAT_SCANS(RS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key shorts its column strobe onto its row.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && col[c]) row[r] = 1'b1;
    end

    typedef struct {
        bit         valid;
        logic [3:0] code;
        bit         held;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (one step per full scan) -------------
    int         m_last;      // previous scan's class: -1 none, -2 ghost, else key index
    int         m_run;       // length of the current run of identical classes
    int         m_held;      // index of the held key, -1 when nothing held
    int         m_rep;       // scans since last report while holding
    logic [3:0] m_code;

    function automatic int class_of(input logic [11:0] p);
        int n = $countones(p);
        if (n == 0) return -1;
        if (n > 1)  return -2;
        for (int i = 0; i < 12; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] code_of(input int idx);
        if (idx < 9)   return 4'(idx + 1);
        if (idx == 9)  return 4'hA;
        if (idx == 10) return 4'h0;
        return 4'hB;
    endfunction

    task automatic model_reset();
        m_last = -1; m_run = 0; m_held = -1; m_rep = 0; m_code = 4'h0;
    endtask

    task automatic model_step(input logic [11:0] p);
        exp_t e;
        int   c = class_of(p);
        if (c == m_last) m_run++;
        else begin m_run = 1; m_last = c; end
        e.valid = 1'b0;
        if (m_held < 0) begin
            if (c >= 0 && m_run >= DB) begin
                e.valid = 1'b1; m_code = code_of(c); m_held = c; m_rep = 0;
            end
        end else begin
            if (c == -1 && m_run >= DB) m_held = -1;
`ifdef KEYPAD_REPEAT_EN
            else if (c == m_held && m_run >= DB) begin
                m_rep++;
                if (m_rep >= RS) begin e.valid = 1'b1; m_rep = 0; end
            end else m_rep = 0;
`endif
        end
        e.code = m_code;
        e.held = (m_held >= 0);
        q.push_back(e);
    endtask

    // ---------------- driver helpers (always entered on a negedge) ---------
    task automatic run_scan(input logic [11:0] p);
        pressed = p;
        model_step(p);
        repeat (SCAN) @(negedge clk);
    endtask

    task automatic run_scans(input logic [11:0] p, input int n);
        for (int i = 0; i < n; i++) run_scan(p);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        q.delete();
        repeat (ncyc) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [11:0] key(input int idx);
        logic [11:0] one = 12'd1;
        return one << idx;
    endfunction

    // ---------------- monitor ----------------------------------------------
    bit   rst_at_pos = 1'b0;
    int   t = 0;
    int   scan_no = 0;
    exp_t e_mon;

    always @(posedge clk) rst_at_pos <= rst;

    always @(negedge clk) begin
        if (rst_at_pos) begin
            t = 0;
            scan_no = 0;
            chk("reset_col",   32'(col),       32'h1);
            chk("reset_code",  32'(key_code),  32'h0);
            chk("reset_valid", 32'(key_valid), 32'h0);
            chk("reset_held",  32'(key_held),  32'h0);
        end else begin
            t++;
            chk("col_strobe", 32'(col), 32'(3'b001 << ((t / SD) % 3)));
            if ((t % SCAN == 1) && (t > SCAN)) begin
                if (q.size() == 0) begin
                    chk("scoreboard_empty", 32'(q.size()), 32'd1);
                end else begin
                    e_mon = q.pop_front();
                    $display("scan %0d: valid=%0b code=%h held=%0b | expect valid=%0b code=%h held=%0b",
                             scan_no, key_valid, key_code, key_held, e_mon.valid, e_mon.code, e_mon.held);
                    chk("key_valid", 32'(key_valid), 32'(e_mon.valid));
                    chk("key_code",  32'(key_code),  32'(e_mon.code));
                    chk("key_held",  32'(key_held),  32'(e_mon.held));
                end
                scan_no++;
            end else begin
                chk("spurious_valid", 32'(key_valid), 32'h0);
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        logic [11:0] p;
        int a, b, kind;

        model_reset();
        pressed = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // idle, then a clean press of '5' and its release
        run_scans('0, 2);
        run_scans(key(4), 5);
        run_scans('0, 4);

        // scan-level bounce on '4', then a stable hold
        run_scan(key(3)); run_scan('0); run_scan(key(3)); run_scan(key(3));
        run_scan('0); run_scan(key(3)); run_scan('0);
        run_scans(key(3), 4);
        run_scans('0, 4);

        // ghost '1' + '#', then '#' released leaving '1'
        run_scans(key(0) | key(11), 6);
        run_scans(key(0), 4);
        run_scans('0, 4);

        // rollover then reset mid-scan with '0' still down
        run_scans(key(9), 4);
        run_scans(key(9) | key(10), 2);
        pressed = key(10);
        repeat (6) @(negedge clk);
        do_reset(1);
        run_scans(key(10), 4);
        run_scans('0, 4);

        // long hold of '9' (repeats when the feature is built in)
        run_scans(key(8), 10);
        run_scans('0, 4);

        // randomised segments: none, single keys, ghosts, other key while held
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 11);
            b = (a + 1 + $urandom_range(0, 10)) % 12;
            case (kind)
                0:       p = '0;
                2:       p = key(a) | key(b);
                default: p = key(a);
            endcase
            run_scans(p, $urandom_range(1, 5));
        end
        run_scans('0, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
